// File: rtl/regfile_seq.sv
// Parametrised register file for the teaching CPU datapath.
//
// One command port handles four operations: load-immediate, ALU write-back, a
// multi-cycle clear sweep and a display latch. Two combinational read ports
// supply ALU operands A and B.
//
// Ports:
//   clock, reset              clock; asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake; ready is low only while a clear runs
//   cmd_op, cmd_addr          opcode and target register
//   cmd_imm, cmd_data         LOAD immediate (zero-extended) and WB data
//   rd_addr_a/b, rd_data_a/b  combinational read ports (optional write bypass)
//   disp_valid, disp_data     registered display latch with a one-cycle valid pulse
//   clr_busy, clr_done        clear sweep in progress / one-cycle completion pulse
module regfile_seq #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned IMM_W   = 5,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [IMM_W-1:0]  cmd_imm,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [2:0] OpLoad  = 3'b000;
  localparam logic [2:0] OpWb    = 3'b001;
  localparam logic [2:0] OpClear = 3'b110;
  localparam logic [2:0] OpDisp  = 3'b111;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic                clr_done_q, clr_done_d;

  logic                accept;
  logic                wr_en;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   wr_data;

  // Stored value, optionally overridden by the write being accepted this cycle,
  // and finally forced to zero for a hardwired R0.
  function automatic logic [DATA_W-1:0] resolve(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] stored,
                                                input logic              wr_hit,
                                                input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYPASS && wr_hit) v = wdata;
    if (R0_ZERO && (addr == '0)) v = '0;
    return v;
  endfunction

  assign cmd_ready = (state_q == StIdle);
  assign clr_busy  = (state_q == StClear);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_en     = accept && ((cmd_op == OpLoad) || (cmd_op == OpWb));

  // Zero-extend without a replication count that would vanish when IMM_W == DATA_W.
  always_comb begin
    imm_ext = '0;
    imm_ext[IMM_W-1:0] = cmd_imm;
  end

  assign wr_data = (cmd_op == OpLoad) ? imm_ext : cmd_data;

  assign rd_data_a = resolve(rd_addr_a, mem_q[rd_addr_a], wr_en && (cmd_addr == rd_addr_a),
                             wr_data);
  assign rd_data_b = resolve(rd_addr_b, mem_q[rd_addr_b], wr_en && (cmd_addr == rd_addr_b),
                             wr_data);

  // Register array next state: command write, then the sweep clear.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && !(R0_ZERO && (cmd_addr == '0))) mem_d[cmd_addr] = wr_data;
    if (state_q == StClear) mem_d[ptr_q] = '0;
  end

  // Sweep controller and display latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clr_done_d   = 1'b0;
    disp_valid_d = 1'b0;
    disp_data_d  = disp_data_q;

    unique case (state_q)
      StIdle: begin
        if (accept && (cmd_op == OpClear)) begin
          state_d = StClear;
          ptr_d   = '0;
        end
        if (accept && (cmd_op == OpDisp)) begin
          disp_valid_d = 1'b1;
          // wr_en is low for a DISPLAY, so the bypass path cannot fire here.
          disp_data_d  = resolve(cmd_addr, mem_q[cmd_addr], wr_en, wr_data);
        end
      end
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      mem_q        <= '{default: '0};
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mem_q        <= mem_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_regfile_seq.sv
module tb_regfile_seq;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_WB    = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_DISP  = 3'b111;

  // Observation points for scoreboard entries.
  localparam int P_A    = 0;
  localparam int P_B    = 1;
  localparam int P_RDY  = 2;
  localparam int P_BUSY = 3;
  localparam int P_DONE = 4;
  localparam int P_DV   = 5;
  localparam int P_DD   = 6;
  localparam int P_XA   = 7;
  localparam int P_XB   = 8;
  localparam int P_XDD  = 9;
  localparam int P_XRDY = 10;
  localparam int P_XDON = 11;
  localparam int P_XBSY = 12;
  localparam int P_XDV  = 13;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [4:0]  cmd_imm;
  logic [15:0] cmd_data;
  logic [3:0]  rd_addr_a, rd_addr_b;

  logic        cmd_ready, disp_valid, clr_busy, clr_done;
  logic [15:0] rd_data_a, rd_data_b, disp_data;
  logic        x_cmd_ready, x_disp_valid, x_clr_busy, x_clr_done;
  logic [15:0] x_rd_data_a, x_rd_data_b, x_disp_data;

  always #5 clock = ~clock;

  // Default build: BYPASS = 1, R0_ZERO = 0.
  regfile_seq dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_imm   (cmd_imm),
    .cmd_data  (cmd_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .disp_valid(disp_valid),
    .disp_data (disp_data),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  // Alternate build sharing the same stimulus: BYPASS = 0, R0_ZERO = 1.
  regfile_seq #(
    .BYPASS (1'b0),
    .R0_ZERO(1'b1)
  ) dut_x (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (x_cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_imm   (cmd_imm),
    .cmd_data  (cmd_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (x_rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (x_rd_data_b),
    .disp_valid(x_disp_valid),
    .disp_data (x_disp_data),
    .clr_busy  (x_clr_busy),
    .clr_done  (x_clr_done)
  );

  typedef struct {
    string       tag;
    int          port;
    logic [15:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] m  [16];  // reference contents, default build
  logic [15:0] mx [16];  // reference contents, alternate build

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  function automatic logic [15:0] obs(input int port);
    case (port)
      P_A:     return rd_data_a;
      P_B:     return rd_data_b;
      P_RDY:   return {15'b0, cmd_ready};
      P_BUSY:  return {15'b0, clr_busy};
      P_DONE:  return {15'b0, clr_done};
      P_DV:    return {15'b0, disp_valid};
      P_DD:    return disp_data;
      P_XA:    return x_rd_data_a;
      P_XB:    return x_rd_data_b;
      P_XDD:   return x_disp_data;
      P_XRDY:  return {15'b0, x_cmd_ready};
      P_XDON:  return {15'b0, x_clr_done};
      P_XBSY:  return {15'b0, x_clr_busy};
      P_XDV:   return {15'b0, x_disp_valid};
      default: return 'x;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int port, input logic [15:0] val);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  // Sample mid-cycle, drain the scoreboard, then advance to just past the next edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs(e.port), e.val);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] addr,
                       input logic [4:0] imm, input logic [15:0] data);
    cmd_valid = v;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_imm   = imm;
    cmd_data  = data;
  endtask

  task automatic idle();
    drive(1'b0, OP_LOAD, 4'd0, 5'd0, 16'h0000);
  endtask

  initial begin
    idle();
    rd_addr_a = '0;
    rd_addr_b = '0;
    for (int i = 0; i < 16; i++) begin
      m[i]  = '0;
      mx[i] = '0;
    end

    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state on every address, both ports.
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      rd_addr_b = 4'(15 - a);
      expect_v($sformatf("rst_a%0d", a), P_A, 16'h0);
      expect_v($sformatf("rst_b%0d", a), P_B, 16'h0);
      expect_v($sformatf("rst_xa%0d", a), P_XA, 16'h0);
      if (a == 0) begin
        expect_v("rst_ready", P_RDY, 16'h1);
        expect_v("rst_busy", P_BUSY, 16'h0);
        expect_v("rst_done", P_DONE, 16'h0);
        expect_v("rst_dv", P_DV, 16'h0);
        expect_v("rst_dd", P_DD, 16'h0);
      end
      cycle();
    end

    // LOAD R3 with 5'b10110: bypass build sees it this cycle, the other next cycle.
    drive(1'b1, OP_LOAD, 4'd3, 5'b10110, 16'hFFFF);
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd3;
    expect_v("load_byp_a", P_A, 16'h0016);
    expect_v("load_byp_b", P_B, 16'h0016);
    expect_v("load_nobyp_a", P_XA, 16'h0000);
    cycle();
    m[3] = 16'h0016; mx[3] = 16'h0016;
    idle();
    expect_v("load_after_a", P_A, 16'h0016);
    expect_v("load_after_xa", P_XA, 16'h0016);
    cycle();

    // WB R7 0xBEEF with port A on R7 and port B on an unrelated register.
    drive(1'b1, OP_WB, 4'd7, 5'd0, 16'hBEEF);
    rd_addr_a = 4'd7;
    rd_addr_b = 4'd3;
    expect_v("wb_byp_a", P_A, 16'hBEEF);
    expect_v("wb_nobyp_a", P_XA, 16'h0000);
    expect_v("wb_other_b", P_B, m[3]);
    cycle();
    m[7] = 16'hBEEF; mx[7] = 16'hBEEF;
    idle();
    expect_v("wb_after_a", P_A, 16'hBEEF);
    expect_v("wb_after_xa", P_XA, 16'hBEEF);
    cycle();

    // WB R9 then DISPLAY R9 back to back.
    drive(1'b1, OP_WB, 4'd9, 5'd0, 16'h1234);
    cycle();
    m[9] = 16'h1234; mx[9] = 16'h1234;
    drive(1'b1, OP_DISP, 4'd9, 5'd0, 16'h0000);
    expect_v("disp_pre_dv", P_DV, 16'h0);
    expect_v("disp_ready", P_RDY, 16'h1);
    cycle();
    idle();
    expect_v("disp_dv", P_DV, 16'h1);
    expect_v("disp_dd", P_DD, 16'h1234);
    expect_v("disp_xdv", P_XDV, 16'h1);
    expect_v("disp_xdd", P_XDD, 16'h1234);
    cycle();
    expect_v("disp_dv_drop", P_DV, 16'h0);
    expect_v("disp_dd_hold", P_DD, 16'h1234);
    cycle();

    // WB R0 0xFFFF: discarded and masked in the R0_ZERO build.
    drive(1'b1, OP_WB, 4'd0, 5'd0, 16'hFFFF);
    rd_addr_a = 4'd0;
    expect_v("r0_byp_a", P_A, 16'hFFFF);
    expect_v("r0_zero_xa", P_XA, 16'h0000);
    cycle();
    m[0] = 16'hFFFF;
    idle();
    expect_v("r0_after_a", P_A, 16'hFFFF);
    expect_v("r0_after_xa", P_XA, 16'h0000);
    cycle();

    // Fill R0..R15 with 1..16 using back-to-back WBs.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, OP_WB, 4'(i), 5'd0, 16'(i + 1));
      cycle();
      m[i] = 16'(i + 1);
      if (i != 0) mx[i] = 16'(i + 1);
    end

    // CLEAR, with a LOAD R2 held valid (stalled) through the sweep.
    drive(1'b1, OP_CLEAR, 4'd0, 5'd0, 16'h0000);
    expect_v("clr_acc_ready", P_RDY, 16'h1);
    expect_v("clr_acc_busy", P_BUSY, 16'h0);
    cycle();
    drive(1'b1, OP_LOAD, 4'd2, 5'h1F, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      rd_addr_a = (k == 0) ? 4'd0 : 4'(k - 1);
      rd_addr_b = 4'(k);
      expect_v($sformatf("sw_ready%0d", k), P_RDY, 16'h0);
      expect_v($sformatf("sw_busy%0d", k), P_BUSY, 16'h1);
      expect_v($sformatf("sw_done%0d", k), P_DONE, 16'h0);
      expect_v($sformatf("sw_xready%0d", k), P_XRDY, 16'h0);
      expect_v($sformatf("sw_xbusy%0d", k), P_XBSY, 16'h1);
      if (k == 0) begin
        expect_v("sw_a0", P_A, m[0]);
        expect_v("sw_xa0", P_XA, mx[0]);
      end else begin
        expect_v($sformatf("sw_cleared_a%0d", k - 1), P_A, 16'h0);
        expect_v($sformatf("sw_cleared_xa%0d", k - 1), P_XA, 16'h0);
      end
      expect_v($sformatf("sw_pending_b%0d", k), P_B, m[k]);
      expect_v($sformatf("sw_pending_xb%0d", k), P_XB, mx[k]);
      cycle();
    end
    // Ready returns with the done pulse; the stalled LOAD is taken on this edge.
    rd_addr_a = 4'd2;
    rd_addr_b = 4'd5;
    expect_v("end_ready", P_RDY, 16'h1);
    expect_v("end_busy", P_BUSY, 16'h0);
    expect_v("end_done", P_DONE, 16'h1);
    expect_v("end_xdone", P_XDON, 16'h1);
    expect_v("end_byp_a", P_A, 16'h001F);
    expect_v("end_nobyp_xa", P_XA, 16'h0000);
    expect_v("end_b", P_B, 16'h0000);
    cycle();
    for (int i = 0; i < 16; i++) begin
      m[i]  = '0;
      mx[i] = '0;
    end
    m[2] = 16'h001F; mx[2] = 16'h001F;
    idle();
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      rd_addr_b = 4'(a);
      if (a == 0) expect_v("post_done", P_DONE, 16'h0);
      expect_v($sformatf("post_a%0d", a), P_A, m[a]);
      expect_v($sformatf("post_xb%0d", a), P_XB, mx[a]);
      cycle();
    end

    // Reset during the sweep.
    drive(1'b1, OP_WB, 4'd10, 5'd0, 16'hAAAA);
    cycle();
    drive(1'b1, OP_DISP, 4'd10, 5'd0, 16'h0000);
    cycle();
    drive(1'b1, OP_CLEAR, 4'd0, 5'd0, 16'h0000);
    cycle();
    idle();
    rd_addr_a = 4'd10;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        expect_v("mid_busy", P_BUSY, 16'h1);
        expect_v("mid_dd", P_DD, 16'hAAAA);
        expect_v("mid_a10", P_A, 16'hAAAA);
      end
      cycle();
    end
    reset = 1'b1;
    expect_v("mrst_ready", P_RDY, 16'h1);
    expect_v("mrst_busy", P_BUSY, 16'h0);
    expect_v("mrst_a10", P_A, 16'h0);
    expect_v("mrst_xa10", P_XA, 16'h0);
    expect_v("mrst_dd", P_DD, 16'h0);
    expect_v("mrst_dv", P_DV, 16'h0);
    cycle();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      expect_v($sformatf("mrst_nodone%0d", k), P_DONE, 16'h0);
      expect_v($sformatf("mrst_xnodone%0d", k), P_XDON, 16'h0);
      expect_v($sformatf("mrst_idle%0d", k), P_RDY, 16'h1);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_seq.md
# regfile_seq

Parametrised register file for the teaching CPU datapath, the successor to the 16×16 single-read-port register memory. It holds `DEPTH` words of `DATA_W` bits. One command port performs load-immediate, ALU write-back, a sequential clear sweep and a display latch, and two combinational read ports feed operands A and B to the ALU. A ready/valid handshake stalls the controller while the multi-cycle clear runs.

## Interface
Parameters:
- `DATA_W`, default 16: word width.
- `ADDR_W`, default 4: address width; `DEPTH` = 2^`ADDR_W`.
- `IMM_W`, default 5: immediate width. `IMM_W` ≤ `DATA_W` is required.
- `BYPASS`, default 1: when 1, read ports forward same-cycle write data.
- `R0_ZERO`, default 0: when 1, register 0 is hardwired to zero.

Ports:
- `clock` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted.
- `cmd_op` in 3: opcode.
- `cmd_addr` in `ADDR_W`: target register.
- `cmd_imm` in `IMM_W`: immediate for LOAD.
- `cmd_data` in `DATA_W`: write-back data for WB.
- `rd_addr_a` in `ADDR_W`: read port A address.
- `rd_data_a` out `DATA_W`: read port A data.
- `rd_addr_b` in `ADDR_W`: read port B address.
- `rd_data_b` out `DATA_W`: read port B data.
- `disp_valid` out 1: one-cycle pulse; `disp_data` has been updated.
- `disp_data` out `DATA_W`: latched display value.
- `clr_busy` out 1: clear sweep in progress.
- `clr_done` out 1: one-cycle pulse when the sweep completes.

## Operation
- **Accept rule.** A command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both high. `cmd_ready` = (state == IDLE), driven combinationally. Commands presented while not ready are not accepted; the controller must hold them.
- **Opcodes:**
  - LOAD 000: `reg[cmd_addr]` ← zero-extended `cmd_imm`.
  - WB 001: `reg[cmd_addr]` ← `cmd_data`.
  - CLEAR 110: start the sweep.
  - DISPLAY 111: `disp_data` ← `reg[cmd_addr]`, using the read value including bypass.
  - 010–101: accepted with no effect.
- **R0_ZERO = 1:** writes to address 0 are discarded, and reads of address 0 return 0 regardless of bypass.
- **Read ports:** combinational, `rd_data_x` = `reg[rd_addr_x]`.
  - With `BYPASS` = 1, when a LOAD or WB is being accepted this cycle and `cmd_addr` == `rd_addr_x`, `rd_data_x` returns the value being written.
  - With `BYPASS` = 0, the old value is returned until after the edge.
- **State machine:** two states, IDLE and CLEAR, plus a sweep pointer `ptr` of `ADDR_W` bits.
  - IDLE → CLEAR on acceptance of CLEAR; `ptr` ← 0.
  - In CLEAR, each edge writes `reg[ptr]` ← 0 and increments `ptr`.
  - On the edge that clears `ptr` == `DEPTH`−1: state → IDLE and `clr_done` ← 1 for one cycle.
- **During the sweep:** reads of already-cleared registers return 0; not-yet-cleared registers return their old contents. `clr_busy` = (state == CLEAR).
- **Reset**, at any time including mid-sweep, takes effect immediately:
  - all registers = 0, state IDLE, `ptr` = 0;
  - `disp_data` = 0, `disp_valid` = 0, `clr_done` = 0;
  - `cmd_ready` = 1 (not during reset assertion guaranteed? no: `cmd_ready` reads 1 once state is IDLE, i.e. immediately).

## Timing
- **LOAD/WB:** the written value is visible on the read ports the cycle after acceptance, or in the same cycle with `BYPASS` = 1.
- **DISPLAY:** `disp_data` and `disp_valid` are registered; both update on the accept edge. `disp_valid` is high for exactly one cycle; `disp_data` holds until the next DISPLAY.
- **CLEAR:** occupies `DEPTH` edges after the accept edge.
  - `cmd_ready` is low for exactly `DEPTH` cycles.
  - `clr_done` is high during the cycle in which `cmd_ready` returns high.
  - A command may be accepted on that same cycle's edge.
- **Throughput:** one LOAD, WB or DISPLAY per cycle back-to-back, with no bubbles.
- **Simultaneous events:** a WB and a read of the same address in one cycle is resolved by `BYPASS` as above. Reset overrides everything.

## Test plan
- **Reset then read:** reset pulse, then read all 16 addresses on both ports → 0x0000 everywhere; `cmd_ready` = 1; `clr_busy` = 0.
- **LOAD / WB / bypass:**
  - LOAD R3 imm 5'b10110 → R3 = 0x0016 next cycle.
  - WB R7 0xBEEF with `rd_addr_a` = 7 in the same cycle → `rd_data_a` = 0xBEEF in that cycle (`BYPASS` = 1), and the old value with `BYPASS` = 0.
- **Clear sweep:**
  - Setup: load R0..R15 = 1..16.
  - Stimulus: CLEAR.
  - Response: `cmd_ready` low for 16 cycles; after 4 sweep edges R3 = 0 and R4 = 5; `clr_done` pulses once; all registers = 0 afterwards.
- **Stall:** hold LOAD R2 valid during the sweep → not applied until `cmd_ready` = 1, then applied once.
- **Display:** WB R9 0x1234, then DISPLAY R9 → `disp_data` = 0x1234 with a one-cycle `disp_valid`.
- **Reset mid-sweep / R0_ZERO:**
  - Assert reset at sweep cycle 6 → all zero, IDLE, `clr_done` never pulses.
  - With `R0_ZERO` = 1, WB R0 0xFFFF → reads 0x0000.
